ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

Execute-to-memory pipeline stage that sits directly downstream of the ALU. It captures the ALU result and NZVC flags together with the instruction's write-back and memory-control fields into a 2-entry elastic buffer that feeds the memory stage. It maintains the architectural flag register and provides a forwarding tap back to the ALU operand selection. A valid/ready handshake on both sides decouples execute from memory-stage stalls.

## Interface
- `WIDTH`, 16: datapath width; must match the ALU's `WIDTH`.
- `RADDR`, 4: destination register index width.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: execute stage presents an instruction.
- `in_ready` out 1: stage can accept this cycle.
- `alu_out` in WIDTH: ALU result.
- `alu_n`, `alu_z`, `alu_v`, `alu_c` in 1 each: ALU flags.
- `in_set_flags` in 1: instruction updates the flag register.
- `in_rd` in RADDR: destination register.
- `in_wb_en` in 1: instruction writes the register file.
- `in_mem_rd`, `in_mem_wr` in 1 each: load or store; both high is illegal.
- `in_store_data` in WIDTH: store operand.
- `flush` in 1: discard all buffered and incoming instructions.
- `out_valid` out 1: head entry valid toward the memory stage.
- `out_ready` in 1: memory stage accepts the head entry.
- `out_result` out WIDTH: head entry result, which is the memory address for loads and stores.
- `out_rd`, `out_wb_en`, `out_mem_rd`, `out_mem_wr`, `out_store_data`: head entry fields.
- `flags` out 4: architectural {N,Z,C,V}.
- `fwd_valid` out 1, `fwd_rd` out RADDR, `fwd_data` out WIDTH: forwarding tap.

## Operation
- Storage is a 2-entry FIFO with 1-bit head/tail pointers and a 2-bit count (0..2).
- Push: `in_valid && in_ready && !flush`. The entry captures `alu_out`, `in_rd`, `in_wb_en`, `in_mem_rd`, `in_mem_wr` and `in_store_data`.
- Pop: `out_valid && out_ready && !flush`.
- `in_ready = (count != 2)`. It is driven from registers only, with no combinational path from `out_ready`.
- `out_valid = (count != 0)`. The `out_*` fields show the head entry and hold stable while `out_valid && !out_ready`.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Count 2 with `out_ready` high: pop only, because `in_ready` is low.
- Flag register: on a push with `in_set_flags` set, `flags` ← {`alu_n`, `alu_z`, `alu_c`, `alu_v`}. Otherwise `flags` holds its value.
- Flush: at the next edge, count, head and tail are all set to 0. A same-cycle push is dropped, and flags are not modified by a dropped push. Flags already committed are not reverted.
- Forwarding (macro-controlled, see Configuration):
  - Source is the most recently pushed valid entry.
  - `fwd_valid = out_valid && newest.wb_en && !newest.mem_rd`. Load data is not available here.
  - `fwd_rd` and `fwd_data` come from that entry.

## Timing
- Reset values:
  - count, head and tail are 0.
  - `out_valid` = 0 and `in_ready` = 1.
  - All `out_*` data fields are 0.
  - `flags` = 4'b0000.
  - `fwd_valid` = 0.
- Latency: a push at edge k appears on `out_*` with `out_valid` = 1 after edge k, so it is visible in cycle k+1. There is no same-cycle pass-through.
- Throughput: 1 instruction per cycle while `out_ready` is held high.
- Flags: a push at edge k is visible on `flags` in cycle k+1.
- Reset mid-operation: asynchronous. All state clears immediately and in-flight entries are lost.
- Simultaneous `flush` and `rst_n` low: reset dominates.

## Configuration
- `EXMEM_FORWARD_EN` defined: the forwarding logic described in Operation is compiled in.
- `EXMEM_FORWARD_EN` undefined:
  - `fwd_valid` is tied to 0, and `fwd_rd` and `fwd_data` are tied to 0.
  - The ports remain present.
  - All other behaviour is identical.

## Test plan
- Reset, then push `alu_out`=16'h1234, `in_rd`=3, `in_wb_en`=1 with `out_ready`=1 → next cycle `out_valid`=1, `out_result`=16'h1234, `out_rd`=3. With `EXMEM_FORWARD_EN`: `fwd_valid`=1, `fwd_data`=16'h1234.
- Hold `out_ready`=0 and push 16'h0001 then 16'h0002 → after the second push `in_ready`=0. Raise `out_ready` → pops return 0001 then 0002 in order, and `in_ready` returns to 1 after the first pop.
- Push with `in_set_flags`=1 and {n,z,c,v}=4'b0110, then push with `in_set_flags`=0 and 4'b1001 → `flags`=4'b0110 in both following cycles.
- Fill both entries, then assert `flush` together with a push that has `in_set_flags`=1 → next cycle `out_valid`=0, count is 0, and `flags` is unchanged.
- Push a load (`in_mem_rd`=1, `in_wb_en`=1, `in_rd`=5) → `fwd_valid`=0 while the entry is present; `out_mem_rd`=1 and `out_result` equals the address.
- Drive `rst_n` low asynchronously while 2 entries are held → outputs clear immediately to their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/ex_mem_stage.sv
// Execute-to-memory pipeline stage: 2-entry elastic buffer, flag register and forwarding tap.
// Optional macro EXMEM_FORWARD_EN compiles in the forwarding tap; otherwise it is tied to zero.
module ex_mem_stage #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned RADDR = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_v,
    input  logic             alu_c,
    input  logic             in_set_flags,
    input  logic [RADDR-1:0] in_rd,
    input  logic             in_wb_en,
    input  logic             in_mem_rd,
    input  logic             in_mem_wr,
    input  logic [WIDTH-1:0] in_store_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [RADDR-1:0] out_rd,
    output logic             out_wb_en,
    output logic             out_mem_rd,
    output logic             out_mem_wr,
    output logic [WIDTH-1:0] out_store_data,
    output logic [3:0]       flags,
    output logic             fwd_valid,
    output logic [RADDR-1:0] fwd_rd,
    output logic [WIDTH-1:0] fwd_data
);

    localparam int unsigned DEPTH = 2;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [RADDR-1:0] rd;
        logic             wb_en;
        logic             mem_rd;
        logic             mem_wr;
        logic [WIDTH-1:0] store_data;
    } entry_t;

    entry_t      mem_q [DEPTH];
    entry_t      in_entry;
    entry_t      head_entry;
    logic        head_q, head_d;
    logic        tail_q, tail_d;
    logic [1:0]  count_q, count_d;
    logic [3:0]  flags_q, flags_d;
    logic        push;
    logic        pop;

    // Handshake status depends on the count register only.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    assign in_entry = '{
        result:     alu_out,
        rd:         in_rd,
        wb_en:      in_wb_en,
        mem_rd:     in_mem_rd,
        mem_wr:     in_mem_wr,
        store_data: in_store_data
    };

    // Pointer, occupancy and flag next-state.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        flags_d = flags_q;
        if (flush) begin
            head_d  = 1'b0;
            tail_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (push) begin
                tail_d = ~tail_q;
                if (in_set_flags) begin
                    flags_d = {alu_n, alu_z, alu_c, alu_v};
                end
            end
            if (pop) begin
                head_d = ~head_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
            flags_q <= 4'b0000;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            flags_q <= flags_d;
        end
    end

    // Entry storage is cleared on reset so the head fields read zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[tail_q] <= in_entry;
        end
    end

    assign head_entry     = mem_q[head_q];
    assign out_result     = head_entry.result;
    assign out_rd         = head_entry.rd;
    assign out_wb_en      = head_entry.wb_en;
    assign out_mem_rd     = head_entry.mem_rd;
    assign out_mem_wr     = head_entry.mem_wr;
    assign out_store_data = head_entry.store_data;
    assign flags          = flags_q;

`ifdef EXMEM_FORWARD_EN
    // The newest entry sits just behind the tail; loads cannot forward yet.
    entry_t newest_entry;
    logic   newest_idx;

    assign newest_idx   = tail_q - 1'b1;
    assign newest_entry = mem_q[newest_idx];
    assign fwd_valid    = out_valid && newest_entry.wb_en && !newest_entry.mem_rd;
    assign fwd_rd       = newest_entry.rd;
    assign fwd_data     = newest_entry.result;
`else
    assign fwd_valid    = 1'b0;
    assign fwd_rd       = '0;
    assign fwd_data     = '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed steps plus random traffic against a queue-based reference model.
// Honours EXMEM_FORWARD_EN the same way the design does.
module tb_ex_mem_stage;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned RADDR = 4;

    typedef struct {
        logic [WIDTH-1:0] result;
        logic [RADDR-1:0] rd;
        logic             wb_en;
        logic             mem_rd;
        logic             mem_wr;
        logic [WIDTH-1:0] store_data;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] alu_out;
    logic             alu_n, alu_z, alu_v, alu_c;
    logic             in_set_flags;
    logic [RADDR-1:0] in_rd;
    logic             in_wb_en, in_mem_rd, in_mem_wr;
    logic [WIDTH-1:0] in_store_data;
    logic             flush;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] out_result;
    logic [RADDR-1:0] out_rd;
    logic             out_wb_en, out_mem_rd, out_mem_wr;
    logic [WIDTH-1:0] out_store_data;
    logic [3:0]       flags;
    logic             fwd_valid;
    logic [RADDR-1:0] fwd_rd;
    logic [WIDTH-1:0] fwd_data;

    int   n_cmp = 0;
    int   n_err = 0;
    ent_t q[$];
    logic [3:0] flags_m;

    ex_mem_stage #(.WIDTH(WIDTH), .RADDR(RADDR)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c),
        .in_set_flags(in_set_flags), .in_rd(in_rd), .in_wb_en(in_wb_en),
        .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr), .in_store_data(in_store_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_wb_en(out_wb_en),
        .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_store_data(out_store_data),
        .flags(flags),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] res, input logic [RADDR-1:0] rd,
                         input logic wb, input logic mrd, input logic mwr, input logic [WIDTH-1:0] sd,
                         input logic sf, input logic [3:0] nzcv, input logic ordy, input logic fl);
        in_valid      = v;
        alu_out       = res;
        in_rd         = rd;
        in_wb_en      = wb;
        in_mem_rd     = mrd;
        in_mem_wr     = mwr;
        in_store_data = sd;
        in_set_flags  = sf;
        {alu_n, alu_z, alu_c, alu_v} = nzcv;
        out_ready     = ordy;
        flush         = fl;
    endtask

    task automatic check_outputs();
        logic exp_fv;
        logic [RADDR-1:0] exp_frd;
        logic [WIDTH-1:0] exp_fdata;
        check("in_ready", 32'(in_ready), 32'(q.size() != 2));
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        check("flags", 32'(flags), 32'(flags_m));
        if (q.size() != 0) begin
            check("out_result", 32'(out_result), 32'(q[0].result));
            check("out_rd", 32'(out_rd), 32'(q[0].rd));
            check("out_wb_en", 32'(out_wb_en), 32'(q[0].wb_en));
            check("out_mem_rd", 32'(out_mem_rd), 32'(q[0].mem_rd));
            check("out_mem_wr", 32'(out_mem_wr), 32'(q[0].mem_wr));
            check("out_store_data", 32'(out_store_data), 32'(q[0].store_data));
        end
        exp_fv = 1'b0;
        exp_frd = '0;
        exp_fdata = '0;
`ifdef EXMEM_FORWARD_EN
        if (q.size() != 0) begin
            exp_fv    = q[$].wb_en && !q[$].mem_rd;
            exp_frd   = q[$].rd;
            exp_fdata = q[$].result;
        end
        if (exp_fv) begin
            check("fwd_rd", 32'(fwd_rd), 32'(exp_frd));
            check("fwd_data", 32'(fwd_data), 32'(exp_fdata));
        end
`else
        check("fwd_rd", 32'(fwd_rd), 32'(exp_frd));
        check("fwd_data", 32'(fwd_data), 32'(exp_fdata));
`endif
        check("fwd_valid", 32'(fwd_valid), 32'(exp_fv));
    endtask

    // One clock: check at the falling edge, then advance the model with the DUT.
    task automatic cycle();
        logic push, pop;
        ent_t e;
        @(negedge clk);
        check_outputs();
        push = in_valid && (q.size() != 2) && !flush;
        pop  = (q.size() != 0) && out_ready && !flush;
        e.result = alu_out; e.rd = in_rd; e.wb_en = in_wb_en;
        e.mem_rd = in_mem_rd; e.mem_wr = in_mem_wr; e.store_data = in_store_data;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(e);
                if (in_set_flags) flags_m = {alu_n, alu_z, alu_c, alu_v};
            end
        end
        #1;
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 4'h0, ordy, 1'b0);
    endtask

    initial begin
        int k;
        flags_m = 4'b0000;
        rst_n = 1'b0;
        idle(1'b0);
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_result", 32'(out_result), 32'd0);
        check("rst_out_rd", 32'(out_rd), 32'd0);
        check("rst_out_store_data", 32'(out_store_data), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_fwd_valid", 32'(fwd_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single push with immediate visibility next cycle
        drive(1'b1, 16'h1234, 4'd3, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0, 1'b1, 1'b0);
        cycle();
        check("t1_out_result", 32'(out_result), 32'h1234);
        check("t1_out_rd", 32'(out_rd), 32'd3);
`ifdef EXMEM_FORWARD_EN
        check("t1_fwd_valid", 32'(fwd_valid), 32'd1);
        check("t1_fwd_data", 32'(fwd_data), 32'h1234);
`endif
        idle(1'b1);
        cycle();

        // Fill, backpressure, in-order drain
        drive(1'b1, 16'h0001, 4'd1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 16'h0002, 4'd2, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        cycle();
        check("t2_in_ready_full", 32'(in_ready), 32'd0);
        idle(1'b0);
        cycle();
        check("t2_hold_result", 32'(out_result), 32'h0001);
        idle(1'b1);
        cycle();
        check("t2_in_ready_after_pop", 32'(in_ready), 32'd1);
        check("t2_second_result", 32'(out_result), 32'h0002);
        cycle();

        // Flag update only when requested
        drive(1'b1, 16'h00AA, 4'd4, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 4'b0110, 1'b1, 1'b0);
        cycle();
        check("t3_flags_set", 32'(flags), 32'h6);
        drive(1'b1, 16'h00BB, 4'd4, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 4'b1001, 1'b1, 1'b0);
        cycle();
        check("t3_flags_hold", 32'(flags), 32'h6);
        idle(1'b1);
        cycle();

        // Flush drops buffered entries and the same-cycle push
        drive(1'b1, 16'h0C01, 4'd6, 1'b1, 1'b0, 1'b1, 16'h5555, 1'b0, 4'h0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 16'h0C02, 4'd7, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 16'h0C03, 4'd8, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 4'b1111, 1'b0, 1'b1);
        cycle();
        check("t4_out_valid", 32'(out_valid), 32'd0);
        check("t4_flags_kept", 32'(flags), 32'h6);
        idle(1'b0);
        cycle();

        // Load must not forward
        drive(1'b1, 16'h4000, 4'd5, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        cycle();
        check("t5_fwd_valid_load", 32'(fwd_valid), 32'd0);
        check("t5_out_mem_rd", 32'(out_mem_rd), 32'd1);
        check("t5_out_result_addr", 32'(out_result), 32'h4000);
        idle(1'b1);
        cycle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            k = $urandom_range(0, 2);
            drive(($urandom_range(0, 3) != 0), WIDTH'($urandom), RADDR'($urandom),
                  1'($urandom), (k == 1), (k == 2), WIDTH'($urandom),
                  1'($urandom), 4'($urandom), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 19) == 0));
            cycle();
        end

        // Asynchronous reset while two entries are held
        drive(1'b1, 16'hAAAA, 4'd9, 1'b1, 1'b0, 1'b0, 16'h1111, 1'b1, 4'b1010, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 16'hBBBB, 4'd10, 1'b1, 1'b0, 1'b1, 16'h2222, 1'b0, 4'h0, 1'b0, 1'b0);
        cycle();
        idle(1'b0);
        check("t6_full_before_reset", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        flags_m = 4'b0000;
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd1);
        check("t6_out_result", 32'(out_result), 32'd0);
        check("t6_out_rd", 32'(out_rd), 32'd0);
        check("t6_out_mem_wr", 32'(out_mem_wr), 32'd0);
        check("t6_flags", 32'(flags), 32'd0);
        check("t6_fwd_valid", 32'(fwd_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
